// File: rtl/switch_input_port_pkg.sv
// Shared register offsets and sizing helpers for the switch input port.
package switch_input_port_pkg;

  typedef enum logic [1:0] {
    SWIN_LEVEL = 2'd0,
    SWIN_RISE  = 2'd1,
    SWIN_FALL  = 2'd2,
    SWIN_RSVD  = 2'd3
  } swinReg_t;

  // Base of the slot decoded onto slaveSel[2], next to the LED port.
  localparam logic [14:0] SWIN_BASE_ADDR = 15'h6004;

  function automatic int minOneClog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_input_port_debounce_bit.sv
// Single-pin 2-flop synchronizer plus tick-driven debouncer with edge pulses.
// Level follows the pin DEBOUNCE_TICKS ticks after sync; there is no backpressure.
module debounce_bit
  import switch_input_port_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic pin,
  output logic deb,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = minOneClog2(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          settle;

  // High in the single cycle before deb takes the synchronized value.
  assign settle = tick && (sync2 != deb) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      deb   <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (tick) begin
        if (settle) begin
          deb <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign rise_pulse = settle & sync2;
  assign fall_pulse = settle & ~sync2;

endmodule

// File: rtl/switch_input_port.sv
// Memory-mapped debounced switch port: LEVEL plus write-1-to-clear RISE/FALL flags.
// Reads are combinational on addr; writes take effect on the next edge, no backpressure.
module switch_input_port
  import switch_input_port_pkg::*;
#(
  parameter int WIDTH          = 10,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  input  logic [1:0]       addr,
  input  logic [15:0]      in,
  input  logic             load,
  output logic [15:0]      out
);

  localparam int PW = minOneClog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    prescCnt;
  logic             tick;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] risePulse;
  logic [WIDTH-1:0] fallPulse;
  logic [WIDTH-1:0] riseReg;
  logic [WIDTH-1:0] fallReg;
  logic [WIDTH-1:0] riseClr;
  logic [WIDTH-1:0] fallClr;
  logic             unusedIn;

  always_ff @(posedge clk) begin
    if (reset || tick) prescCnt <= '0;
    else               prescCnt <= prescCnt + 1'b1;
  end

  assign tick = (prescCnt == PRESC_LAST);

  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    debounce_bit #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) uBit (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .pin        (pins[i]),
      .deb        (level[i]),
      .rise_pulse (risePulse[i]),
      .fall_pulse (fallPulse[i])
    );
  end

  assign riseClr  = (load && addr == SWIN_RISE) ? in[WIDTH-1:0] : '0;
  assign fallClr  = (load && addr == SWIN_FALL) ? in[WIDTH-1:0] : '0;
  assign unusedIn = ^in;

  // Set is OR-ed in after the clear so a same-cycle event is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      riseReg <= '0;
      fallReg <= '0;
    end else begin
      riseReg <= (riseReg & ~riseClr) | risePulse;
      fallReg <= (fallReg & ~fallClr) | fallPulse;
    end
  end

  always_comb begin
    out = '0;
    if (!reset) begin
      case (swinReg_t'(addr))
        SWIN_LEVEL: out[WIDTH-1:0] = level;
        SWIN_RISE:  out[WIDTH-1:0] = riseReg;
        SWIN_FALL:  out[WIDTH-1:0] = fallReg;
        default:    out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench: dutA uses TICK_DIV=1/DEBOUNCE_TICKS=4, dutB uses TICK_DIV=3/DEBOUNCE_TICKS=2.
module tb_switch_input_port;

  logic        clk;
  logic        resetA, resetB;
  logic [9:0]  pinsA, pinsB;
  logic [1:0]  addrA, addrB;
  logic [15:0] inA, inB;
  logic        loadA, loadB;
  logic [15:0] outA, outB;
  logic [15:0] v;
  logic [15:0] prevB;
  int          vecCount = 0;
  int          missCount = 0;
  int          changes;

  switch_input_port #(.WIDTH(10), .TICK_DIV(1), .DEBOUNCE_TICKS(4)) dutA (
    .clk(clk), .reset(resetA), .pins(pinsA), .addr(addrA),
    .in(inA), .load(loadA), .out(outA)
  );

  switch_input_port #(.WIDTH(10), .TICK_DIV(3), .DEBOUNCE_TICKS(2)) dutB (
    .clk(clk), .reset(resetB), .pins(pinsB), .addr(addrB),
    .in(inB), .load(loadB), .out(outB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic readA(input logic [1:0] a, output logic [15:0] val);
    addrA = a;
    #1;
    val = outA;
  endtask

  task automatic writeA(input logic [1:0] a, input logic [15:0] d);
    addrA = a;
    inA   = d;
    loadA = 1'b1;
    @(negedge clk);
    loadA = 1'b0;
    inA   = 16'h0000;
  endtask

  initial begin
    resetA = 1'b1; resetB = 1'b1;
    pinsA = 10'h3FF; pinsB = 10'h3FF;
    addrA = 2'd0; addrB = 2'd0;
    inA = 16'h0; inB = 16'h0;
    loadA = 1'b0; loadB = 1'b0;

    // Reset: all offsets read zero while reset is held with pins high.
    repeat (3) begin
      @(negedge clk);
      for (int a = 0; a < 4; a++) begin
        readA(2'(a), v);
        checkVal($sformatf("reset_addr%0d", a), v, 16'h0000);
      end
    end
    pinsA = 10'h000;
    pinsB = 10'h200;
    @(negedge clk);
    resetA = 1'b0;
    repeat (4) @(negedge clk);
    readA(2'd0, v); checkVal("idle_level", v, 16'h0000);

    // Clean rise on pin 3: visible after the 6th edge, not the 5th.
    pinsA[3] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (e == 5) begin readA(2'd0, v); checkVal("rise_edge5_level", v, 16'h0000); end
      if (e == 6) begin readA(2'd0, v); checkVal("rise_edge6_level", v, 16'h0008); end
    end
    readA(2'd1, v); checkVal("rise_flag", v, 16'h0008);
    readA(2'd2, v); checkVal("rise_nofall", v, 16'h0000);

    // Bounce on pin 0: two-cycle pulses never reach four ticks.
    for (int p = 0; p < 4; p++) begin
      pinsA[0] = (p % 2 == 0);
      repeat (2) @(negedge clk);
    end
    pinsA[0] = 1'b0;
    repeat (10) @(negedge clk);
    readA(2'd0, v); checkVal("bounce_level", v, 16'h0008);
    readA(2'd1, v); checkVal("bounce_rise", v, 16'h0008);

    // W1C on RISE, writes to LEVEL and reserved ignored.
    pinsA[0] = 1'b1;
    repeat (8) @(negedge clk);
    readA(2'd1, v); checkVal("w1c_pre_rise", v, 16'h0009);
    writeA(2'd1, 16'h0001);
    readA(2'd1, v); checkVal("w1c_rise", v, 16'h0008);
    writeA(2'd0, 16'hFFFF);
    readA(2'd0, v); checkVal("w1c_level_ro", v, 16'h0009);
    writeA(2'd3, 16'hFFFF);
    readA(2'd3, v); checkVal("rsvd_read", v, 16'h0000);
    readA(2'd1, v); checkVal("rsvd_no_clear", v, 16'h0008);

    // Race: clear bits 2 and 3 in the cycle pin 2 settles; bit 2 must survive.
    pinsA[2] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (e == 5) begin
        readA(2'd0, v); checkVal("race_pre_level", v, 16'h0009);
        addrA = 2'd1; inA = 16'h000C; loadA = 1'b1;
      end
      if (e == 6) begin loadA = 1'b0; inA = 16'h0000; end
    end
    readA(2'd1, v); checkVal("race_rise", v, 16'h0004);
    readA(2'd0, v); checkVal("race_level", v, 16'h000D);

    // Falling edge on pin 0 and its W1C.
    pinsA[0] = 1'b0;
    repeat (8) @(negedge clk);
    readA(2'd2, v); checkVal("fall_flag", v, 16'h0001);
    readA(2'd0, v); checkVal("fall_level", v, 16'h000C);
    writeA(2'd2, 16'h0001);
    readA(2'd2, v); checkVal("fall_w1c", v, 16'h0000);

    // Reset mid-debounce on pin 5: everything restarts from zero.
    pinsA[5] = 1'b1;
    repeat (3) @(negedge clk);
    resetA = 1'b1;
    @(negedge clk);
    readA(2'd0, v); checkVal("midrst_held", v, 16'h0000);
    resetA = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (e == 5) begin readA(2'd0, v); checkVal("midrst_edge5", v, 16'h0000); end
      if (e == 6) begin readA(2'd0, v); checkVal("midrst_edge6", v, 16'h002C); end
    end
    readA(2'd2, v); checkVal("midrst_fall", v, 16'h0000);

    // dutB prescaler: level changes only land on edges that follow a tick cycle.
    @(negedge clk);
    resetB = 1'b0;
    addrB = 2'd0;
    prevB = 16'h0000;
    changes = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      #1;
      v = outB;
      if (v !== prevB) begin
        changes++;
        checkVal($sformatf("B_tick_align_n%0d", n), 16'(n % 3), 16'h0000);
        prevB = v;
      end
      if (n == 5)  checkVal("B_edge5_level", v, 16'h0000);
      if (n == 6)  checkVal("B_edge6_level", v, 16'h0200);
      if (n == 10) pinsB = 10'h000;
      if (n == 17) checkVal("B_edge17_level", v, 16'h0200);
      if (n == 18) checkVal("B_edge18_level", v, 16'h0000);
    end
    addrB = 2'd1; #1; checkVal("B_rise", outB, 16'h0200);
    addrB = 2'd2; #1; checkVal("B_fall", outB, 16'h0200);
    addrB = 2'd0; #1; checkVal("B_level_final", outB, 16'h0000);
    checkVal("B_level_changes", 16'(changes), 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
